// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional feature macro: UART_ARB_FRAMING_EN (header byte before each payload).
package uart_arb_pkg;

  localparam logic [3:0]  HDR_TAG = 4'hA;
  localparam int unsigned MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE,
`ifdef UART_ARB_FRAMING_EN
    HDR_WAIT,
`endif
    PAY_WAIT
  } state_t;

  // Frame header: fixed tag in the high nibble, requester index in the low nibble.
  function automatic logic [7:0] header_byte(input logic [$clog2(MAX_REQ)-1:0] id);
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signal bundle for uart_tx_arbiter.
// master: requesters/transmitter side; slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_dv;
  logic [7:0]         tx_byte;
  logic               tx_done;
  logic               busy;
  logic [IDW-1:0]     grant_id;
  logic               timeout_err;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_dv, tx_byte, busy, grant_id, timeout_err
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_dv, tx_byte, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first set req_valid bit after ptr, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);
  localparam int unsigned IDW = $clog2(N_REQ);

  // Scan offsets 1..N_REQ from ptr; the last offset revisits ptr itself.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((32'(ptr) + off) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single bytes from N_REQ requesters to a UART
// transmitter, with a tx_done watchdog.
// Optional feature macro: UART_ARB_FRAMING_EN (send 8'hA0|grant_id before each payload).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter logic [31:0] TIMEOUT_CLKS = 32'd10000
) (
  input  logic             CLK,
  input  logic             RST,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(N_REQ);

  state_t           state, state_next;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_id;
  logic [7:0]       tx_byte;
  logic             tx_dv;
  logic             timeout_err;
  logic [N_REQ-1:0] req_ready;
  logic [31:0]      wd;

  logic             found;
  logic [IDW-1:0]   pick_idx;
  logic [7:0]       pick_byte;
  logic             grant;
  logic             send_pay;
  logic             abort;
  logic             wd_hit;
`ifdef UART_ARB_FRAMING_EN
  logic [7:0]       pay_byte;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr),
    .found     (found),
    .idx       (pick_idx)
  );

  assign pick_byte = bus.req_data[{pick_idx, 3'b000} +: 8];

  // Compared one count ahead so the registered abort lands exactly
  // TIMEOUT_CLKS clocks after tx_dv; tx_done in that same cycle wins.
  assign wd_hit = (wd + 32'd1) >= TIMEOUT_CLKS;

  assign bus.req_ready   = req_ready;
  assign bus.tx_dv       = tx_dv;
  assign bus.tx_byte     = tx_byte;
  assign bus.busy        = (state != IDLE);
  assign bus.grant_id    = grant_id;
  assign bus.timeout_err = timeout_err;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-edge action decode.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    send_pay   = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant = 1'b1;
`ifdef UART_ARB_FRAMING_EN
          state_next = HDR_WAIT;
`else
          state_next = PAY_WAIT;
`endif
        end
      end
`ifdef UART_ARB_FRAMING_EN
      HDR_WAIT: begin
        if (bus.tx_done) begin
          send_pay   = 1'b1;
          state_next = PAY_WAIT;
        end else if (wd_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
`endif
      PAY_WAIT: begin
        if (bus.tx_done) begin
          state_next = IDLE;
        end else if (wd_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant bookkeeping, byte latch, pulse outputs and watchdog.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr         <= IDW'(N_REQ - 1);
      grant_id    <= '0;
      tx_byte     <= 8'h00;
      tx_dv       <= 1'b0;
      req_ready   <= '0;
      timeout_err <= 1'b0;
      wd          <= '0;
`ifdef UART_ARB_FRAMING_EN
      pay_byte    <= 8'h00;
`endif
    end else begin
      tx_dv       <= grant | send_pay;
      req_ready   <= '0;
      timeout_err <= abort;
      if (grant) begin
        ptr                 <= pick_idx;
        grant_id            <= pick_idx;
        req_ready[pick_idx] <= 1'b1;
        wd                  <= '0;
`ifdef UART_ARB_FRAMING_EN
        tx_byte  <= header_byte(4'(pick_idx));
        pay_byte <= pick_byte;
`else
        tx_byte  <= pick_byte;
`endif
      end
`ifdef UART_ARB_FRAMING_EN
      else if (send_pay) begin
        tx_byte <= pay_byte;
        wd      <= '0;
      end
`endif
      else if (state != IDLE) begin
        wd <= wd + 32'd1;
      end
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters, legal range 2..16.
REQ-002 The block SHALL have parameter TIMEOUT_CLKS, default 32'd10000: maximum clocks from tx_dv to tx_done before the transfer is aborted.
REQ-003 The block SHALL have port CLK  in  1  clock: one clock, all logic on its rising edge.
REQ-004 The block SHALL have port RST  in  1  reset: synchronous, active-high.
REQ-005 The block SHALL have port req_valid  in  N_REQ  per-requester byte-pending flag.
REQ-006 The block SHALL have port req_data  in  8*N_REQ  per-requester byte, requester i in bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready  out  N_REQ  one-cycle one-hot accept pulse.
REQ-008 The block SHALL have port tx_dv  out  1  one-cycle start pulse to the UART transmitter.
REQ-009 The block SHALL have port tx_byte  out  8  byte to the UART transmitter, stable from tx_dv until tx_done.
REQ-010 The block SHALL have port tx_done  in  1  one-cycle end-of-frame pulse from the UART transmitter.
REQ-011 The block SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 The block SHALL have port grant_id  out  $clog2(N_REQ)  index of the current or most recent grant.
REQ-013 The block SHALL have port timeout_err  out  1  one-cycle pulse on a watchdog abort.

Function
REQ-014 The FSM SHALL have states IDLE, HDR_WAIT, PAY_WAIT; HDR_WAIT exists only with UART_ARB_FRAMING_EN.
REQ-015 In IDLE with any req_valid bit set, the block SHALL grant the first set bit searching from ptr+1 upward, modulo N_REQ.
REQ-016 On a grant at edge k, the block SHALL latch that requester's byte, set ptr and grant_id to the winner, and leave IDLE.
REQ-017 In cycle k+1, req_ready[winner] and tx_dv SHALL both be 1 for exactly one cycle, and the block SHALL not sample req_valid in that cycle.
REQ-018 A requester SHALL hold req_valid and req_data stable until it sees req_ready; requesters with req_valid low SHALL never be granted.
REQ-019 In PAY_WAIT, tx_done SHALL return the FSM to IDLE at the next edge, so the earliest next tx_dv comes 2 cycles after tx_done.
REQ-020 The watchdog SHALL be a 32-bit counter, cleared at each tx_dv and incremented in every WAIT state.
REQ-021 When the watchdog reaches TIMEOUT_CLKS without tx_done, the block SHALL pulse timeout_err, go to IDLE, and keep ptr at the aborted winner.
REQ-022 If tx_done and the timeout occur in the same cycle, tx_done SHALL win and timeout_err SHALL stay 0.
REQ-023 A tx_done seen in IDLE SHALL be ignored.
REQ-024 req_ready SHALL have at most one bit set in any cycle.

Reset
REQ-025 While RST is 1 at an edge, the block SHALL enter IDLE with ptr=N_REQ-1 (requester 0 first), grant_id=0, watchdog=0, tx_byte=8'h00 and all pulse outputs 0.
REQ-026 A reset mid-transfer SHALL abort silently: no timeout_err and no req_ready.

Configuration
REQ-027 With UART_ARB_FRAMING_EN defined, each grant SHALL send header 8'hA0|grant_id first (tx_dv at k+1, req_ready at k+1), then enter HDR_WAIT.
REQ-028 With UART_ARB_FRAMING_EN defined, tx_done in HDR_WAIT SHALL issue the payload tx_dv on the next cycle and enter PAY_WAIT.
REQ-029 With UART_ARB_FRAMING_EN defined, a timeout in either WAIT state SHALL abort the whole frame.
REQ-030 Without UART_ARB_FRAMING_EN, each grant SHALL send the payload byte only.

Structure
REQ-031 Package uart_arb_pkg SHALL hold the state enum, HDR_TAG=4'hA and MAX_REQ=16.
REQ-032 The block SHALL have one sub-module, rr_pick: combinational round-robin first-set finder (req_valid, ptr -> found, idx).
REQ-033 The UART transmitter SHALL be instantiated outside this block.

Verification
REQ-034 Single request, no framing: req_valid=4'b0010, data1=8'h5A -> req_ready=4'b0010 and tx_dv with tx_byte=8'h5A one cycle after the grant edge; busy until tx_done+1.
REQ-035 All four requesters held valid after reset -> grant order 0,1,2,3,0; grant_id follows that order.
REQ-036 Watchdog: TIMEOUT_CLKS=20, tx_done never pulsed -> timeout_err pulses once, 20 clocks after tx_dv, then IDLE; next grant goes to ptr+1.
REQ-037 tx_done on the same cycle the watchdog reaches its limit -> no timeout_err, normal return to IDLE.
REQ-038 Framing enabled, requester 2 sends 8'h33 -> tx_byte sequence 8'hA2 then 8'h33, with second tx_dv one cycle after first tx_done.
REQ-039 RST during PAY_WAIT -> next cycle IDLE, busy=0, ptr=N_REQ-1, no timeout_err.
